// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and instruction memory (slave).
interface if_stage_if #(
   parameter int WIDTH = 32
);
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0] imem_rdata;
   logic             imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, imem handshake with
// pending-redirect tracking, and the IF/ID pipeline register.
//
// state | meaning
// FETCH | normal fetching; a redirect either applies now (ready) or is parked in redir_pc
// DRAIN | wrong-path access still outstanding; wait for it, then jump to redir_pc
module if_stage #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_fetch,
   input  logic             flush_decode,
   input  logic             pcsrc_decode,
   input  logic             jump_decode,
   input  logic [WIDTH-1:0] pc_branch,
   input  logic [WIDTH-1:0] pc_jump,
   if_stage_if.master       imem,
   output logic [WIDTH-1:0] instr_decode,
   output logic [WIDTH-1:0] pc_decode,
   output logic             valid_decode
);

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] redir_pc;
   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] target;
   logic             redirect;

   assign pc_plus4 = pc + WIDTH'(4);
   assign redirect = (pcsrc_decode | jump_decode) & ~stall_fetch;
   assign target   = jump_decode ? pc_jump : pc_branch;

   assign imem.imem_addr = pc;
   assign imem.imem_req  = ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         state        <= FETCH;
         redir_pc     <= '0;
         instr_decode <= NOP_INSTR;
         pc_decode    <= '0;
         valid_decode <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (!stall_fetch) begin
                  if (redirect) begin
                     instr_decode <= NOP_INSTR;
                     valid_decode <= 1'b0;
                     if (imem.imem_ready) begin
                        pc <= target;
                     end else begin
                        redir_pc <= target;
                        state    <= DRAIN;
                     end
                  end else if (imem.imem_ready) begin
                     pc <= pc_plus4;
                     if (flush_decode) begin
                        instr_decode <= NOP_INSTR;
                        valid_decode <= 1'b0;
                     end else begin
                        instr_decode <= imem.imem_rdata;
                        pc_decode    <= pc_plus4;
                        valid_decode <= 1'b1;
                     end
                  end else begin
                     instr_decode <= NOP_INSTR;
                     valid_decode <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               // Stall and new redirects are ignored until the stale access returns.
               instr_decode <= NOP_INSTR;
               valid_decode <= 1'b0;
               if (imem.imem_ready) begin
                  pc    <= redir_pc;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, branch/jump redirects, drain, reset, wrap.
module tb_if_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall_fetch;
   logic        flush_decode;
   logic        pcsrc_decode;
   logic        jump_decode;
   logic [31:0] pc_branch;
   logic [31:0] pc_jump;
   logic        ready;
   logic [31:0] instr_decode;
   logic [31:0] pc_decode;
   logic        valid_decode;

   int passes = 0;
   int total  = 0;

   if_stage_if #(.WIDTH(32)) bus ();

   if_stage #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_fetch  (stall_fetch),
      .flush_decode (flush_decode),
      .pcsrc_decode (pcsrc_decode),
      .jump_decode  (jump_decode),
      .pc_branch    (pc_branch),
      .pc_jump      (pc_jump),
      .imem         (bus.master),
      .instr_decode (instr_decode),
      .pc_decode    (pc_decode),
      .valid_decode (valid_decode)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign bus.imem_rdata = mem(bus.imem_addr);
   assign bus.imem_ready = ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks the visible fetch address plus the whole IF/ID register.
   task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] pcd, input logic vld);
      chk({tag, ".addr"}, bus.imem_addr, addr);
      chk({tag, ".instr"}, instr_decode, instr);
      chk({tag, ".pcd"}, pc_decode, pcd);
      chk({tag, ".valid"}, {31'b0, valid_decode}, {31'b0, vld});
   endtask

   initial begin
      rst = 1'b1; stall_fetch = 1'b0; flush_decode = 1'b0; pcsrc_decode = 1'b0;
      jump_decode = 1'b0; pc_branch = '0; pc_jump = '0; ready = 1'b1;
      step(); step();
      chk("rst.req", {31'b0, bus.imem_req}, 32'd0);
      chk_all("rst", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;
      #1;
      chk("req", {31'b0, bus.imem_req}, 32'd1);

      step(); chk_all("seq4", 32'h4, mem(32'h0), 32'h4, 1'b1);
      step(); chk_all("seq8", 32'h8, mem(32'h4), 32'h8, 1'b1);
      step(); chk_all("seqC", 32'hC, mem(32'h8), 32'hC, 1'b1);

      pcsrc_decode = 1'b1; pc_branch = 32'h40;
      step(); chk_all("br", 32'h40, 32'h0, 32'hC, 1'b0);
      pcsrc_decode = 1'b0;
      step(); chk_all("br44", 32'h44, mem(32'h40), 32'h44, 1'b1);

      pcsrc_decode = 1'b1; jump_decode = 1'b1; pc_branch = 32'h40; pc_jump = 32'h80;
      step(); chk_all("both", 32'h80, 32'h0, 32'h44, 1'b0);
      pcsrc_decode = 1'b0; jump_decode = 1'b0;
      step(); chk_all("j84", 32'h84, mem(32'h80), 32'h84, 1'b1);

      pcsrc_decode = 1'b1; pc_branch = 32'hC;
      step(); chk("toC", bus.imem_addr, 32'hC);
      pcsrc_decode = 1'b0;
      step(); chk_all("at10", 32'h10, mem(32'hC), 32'h10, 1'b1);

      stall_fetch = 1'b1; pcsrc_decode = 1'b1; pc_branch = 32'h300;
      for (int i = 0; i < 3; i++) begin
         step(); chk_all("stall", 32'h10, mem(32'hC), 32'h10, 1'b1);
      end
      stall_fetch = 1'b0; pcsrc_decode = 1'b0;
      step(); chk_all("resume", 32'h14, mem(32'h10), 32'h14, 1'b1);

      flush_decode = 1'b1;
      step(); chk_all("flush", 32'h18, 32'h0, 32'h14, 1'b0);
      flush_decode = 1'b0; ready = 1'b0;
      step(); chk_all("nordy", 32'h18, 32'h0, 32'h14, 1'b0);
      ready = 1'b1;
      step(); step(); chk_all("at20", 32'h20, mem(32'h1C), 32'h20, 1'b1);

      jump_decode = 1'b1; pc_jump = 32'h100; ready = 1'b0;
      step(); chk_all("drain1", 32'h20, 32'h0, 32'h20, 1'b0);
      jump_decode = 1'b0; pcsrc_decode = 1'b1; pc_branch = 32'h40; stall_fetch = 1'b1;
      step(); chk_all("drain2", 32'h20, 32'h0, 32'h20, 1'b0);
      ready = 1'b1;
      step(); chk_all("drain3", 32'h100, 32'h0, 32'h20, 1'b0);
      pcsrc_decode = 1'b0; stall_fetch = 1'b0;
      step(); chk_all("j104", 32'h104, mem(32'h100), 32'h104, 1'b1);

      jump_decode = 1'b1; pc_jump = 32'h200; ready = 1'b0;
      step(); chk("drainR", bus.imem_addr, 32'h104);
      jump_decode = 1'b0; rst = 1'b1; ready = 1'b1;
      #1;
      chk("rstD.req", {31'b0, bus.imem_req}, 32'd0);
      step(); chk_all("rstD", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0; ready = 1'b0;
      step(); chk("rstD.hold", bus.imem_addr, 32'h0);
      ready = 1'b1;
      step(); chk_all("rstD.fetch", 32'h4, mem(32'h0), 32'h4, 1'b1);

      pcsrc_decode = 1'b1; pc_branch = 32'hFFFF_FFFC;
      step(); chk("wrap.to", bus.imem_addr, 32'hFFFF_FFFC);
      pcsrc_decode = 1'b0;
      step(); chk_all("wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC register and the next-PC select: sequential PC+4, branch target, or jump target.
- Owns the instruction-memory request handshake, including the pending-redirect state.
- Owns the IF/ID pipeline register that produces instr_decode / pc_decode for decode.

Parameters:
- WIDTH, 32, datapath/address width (matches `WIDTH).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID as a bubble.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall_fetch  in  1  from hazard unit; freezes PC and IF/ID
- flush_decode  in  1  from decode; clears IF/ID to bubble
- pcsrc_decode  in  1  taken branch resolved in decode
- jump_decode  in  1  jump in decode
- pc_branch  in  WIDTH  branch target from decode
- pc_jump  in  WIDTH  jump target from decode
- imem_rdata  in  WIDTH  instruction word, valid when imem_ready=1
- imem_ready  in  1  memory has returned the word at imem_addr this cycle
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  fetch address (= PC register)
- instr_decode  out  WIDTH  IF/ID instruction
- pc_decode  out  WIDTH  IF/ID PC+4 of that instruction
- valid_decode  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (sync, one cycle):
  - pc <= RESET_PC, state <= FETCH, redir_pc <= 0.
  - instr_decode <= NOP_INSTR, pc_decode <= 0, valid_decode <= 0.
  - imem_req = 0 while rst=1; otherwise 1.
  - Reset mid-DRAIN abandons the pending redirect.
- imem_addr = pc at all times.
  - Address is stable while imem_ready=0: pc changes only on the clock edge where the current fetch completes, or in the redirect cases below.
- redirect = (pcsrc_decode | jump_decode) & ~stall_fetch. target = jump_decode ? pc_jump : pc_branch (jump wins if both are set).
- pc+4 is computed with WIDTH-bit modular add; wraps 32'hFFFF_FFFC -> 0.
- State FETCH:
  - stall_fetch=1: pc, IF/ID and state all hold. Any imem_ready word is dropped and refetched later. pcsrc/jump are ignored.
  - redirect & imem_ready: pc <= target. Returned word is discarded. IF/ID <= bubble.
  - redirect & ~imem_ready: redir_pc <= target, state <= DRAIN, pc holds. IF/ID <= bubble.
  - ~redirect & imem_ready:
    - pc <= pc+4.
    - IF/ID <= {imem_rdata, pc+4, valid=1}, unless flush_decode=1, in which case IF/ID <= bubble.
  - ~redirect & ~imem_ready: pc holds. IF/ID <= bubble (valid=0, NOP_INSTR, pc_decode unchanged).
- State DRAIN (outstanding wrong-path access):
  - IF/ID <= bubble every cycle.
  - imem_ready: pc <= redir_pc, state <= FETCH. The word is discarded.
  - stall_fetch and new redirects are ignored in DRAIN.
- flush_decode alone (no redirect) clears IF/ID but does not change pc.
- Latency: instruction at pc appears on instr_decode the edge after imem_ready=1. Taken branch/jump costs exactly one bubble when imem_ready=1 on the redirect cycle.
- No combinational path from imem_rdata to any output.

Test Plan:
- Reset then imem_ready=1 constant, sequential memory → imem_addr 0,4,8,12 on consecutive cycles. instr_decode follows one cycle later with pc_decode 4,8,12. valid_decode=1 from the second cycle.
- pc=0x10 with imem_ready=1 and stall_fetch=1 for 3 cycles → imem_addr stays 0x10 and IF/ID holds its value. Release stall → fetch resumes at 0x10 with no skipped address.
- pcsrc_decode=1, pc_branch=0x40, imem_ready=1 at pc=0x0C → next imem_addr=0x40. IF/ID gets one bubble (valid 0, instr 0). Then 0x40's word arrives with pc_decode=0x44.
- jump_decode=1 (pc_jump=0x100) while imem_ready=0 at pc=0x20 → imem_addr stays 0x20 until ready. Ready after 2 cycles → next addr 0x100. valid_decode=0 for all intervening cycles.
- pcsrc_decode and jump_decode both 1 (pc_branch=0x40, pc_jump=0x80) → pc <= 0x80.
- rst asserted during DRAIN → next cycle pc=RESET_PC, state FETCH, valid_decode=0, imem_req=0 while rst=1. pc=0xFFFFFFFC fetch completes → next imem_addr=0.
